// File: rtl/mcu_cmd_ptrbank.sv
// mcu_cmd_ptrbank: SPI-loaded bank of DMA address pointers.
// Each channel has a pointer P, shadow S, stride D and wrap mask M.
// Ports: clk, rst_n (async, active low);
//   cmd_ready/cmd_data, param_ready/param_data, spi_byte_cnt: SPI side;
//   mcu_rq_rdy: request-done level; dma_nextaddr/dma_tgt: DMA step;
//   addr_out: pointer bank; spi_data_out: readback; load_busy.
module mcu_cmd_ptrbank #(
  parameter int NCH = 4,
  parameter int AW  = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_ready,
  input  logic            param_ready,
  input  logic [7:0]      cmd_data,
  input  logic [7:0]      param_data,
  input  logic [31:0]     spi_byte_cnt,
  input  logic            mcu_rq_rdy,
  input  logic            dma_nextaddr,
  input  logic [2:0]      dma_tgt,
  output logic [NCH*AW-1:0] addr_out,
  output logic [7:0]      spi_data_out,
  output logic            load_busy
);

  localparam int NB = (AW + 7) / 8;
  localparam int RW = NB * 8;

  typedef enum logic [1:0] {
    IDLE,
    LOADP,
    LOADM
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] p_q [NCH];
  logic [AW-1:0] s_q [NCH];
  logic [AW-1:0] m_q [NCH];
  logic [7:0]    d_q [NCH];

  logic [2:0] ld_ch_q, ld_ch_d;
  logic       rb_q;
  logic [2:0] rb_ch_q;
  logic       rq_q;
  logic [2:0] hist_q;
  logic       int_req_q;
  logic [2:0] int_ch_q;
  logic       pend_q;
  logic [2:0] pend_ch_q;

  logic [2:0] cch;
  logic ch_ok, dma_ok;
  logic is_ldp, is_ldd, is_ldm, is_rb, is_id;
  logic int_cmd;
  logic ld_byte, ld_last, rb_in;
  logic shift_en, commit, cmt_p, cmt_m;
  logic [AW-1:0] p_cmd, p_rb, s_sel, s_new;
  logic [RW-1:0] w_cmd, w_rb;
  logic [2:0] rb_idx;
  logic [7:0] rb_msb, rb_sel;
  logic isrc_v, collide;
  logic [2:0] isrc_ch;

  function automatic logic [AW-1:0] step(
    input logic [AW-1:0] p,
    input logic [7:0]    d,
    input logic [AW-1:0] m
  );
    logic [AW-1:0] sum;
    sum = p + AW'(d);
    return (p & ~m) | (sum & m);
  endfunction

  assign cch    = cmd_data[2:0];
  assign ch_ok  = int'(cch) < NCH;
  assign is_ldp = ch_ok && cmd_data[7:3] == 5'b00000;
  assign is_ldd = ch_ok && cmd_data[7:3] == 5'b00010;
  assign is_ldm = ch_ok && cmd_data[7:3] == 5'b00100;
  assign is_rb  = ch_ok && cmd_data[7:3] == 5'b00110;
  assign is_id  = cmd_data == 8'hF0;

  assign int_cmd = ch_ok && cmd_data[7:5] == 3'b100
                && cmd_data[3]
                && spi_byte_cnt >= 32'd1 + 32'(cmd_data[4]);

  assign ld_byte = spi_byte_cnt >= 32'd2
                && spi_byte_cnt <= 32'(NB + 1);
  assign ld_last = spi_byte_cnt == 32'(NB + 1);
  assign rb_in   = spi_byte_cnt >= 32'd2
                && spi_byte_cnt <= 32'(NB);

  always_comb begin
    p_cmd = '0;
    p_rb  = '0;
    s_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cch == 3'(c)) p_cmd = p_q[c];
      if (rb_ch_q == 3'(c)) p_rb = p_q[c];
      if (ld_ch_q == 3'(c)) s_sel = s_q[c];
    end
  end

  assign s_new  = AW'({s_sel, param_data});
  assign w_cmd  = RW'(p_cmd);
  assign w_rb   = RW'(p_rb);
  assign rb_idx = 3'(NB) - spi_byte_cnt[2:0];
  assign rb_msb = 8'(w_cmd >> (RW - 8));
  assign rb_sel = 8'(w_rb >> {rb_idx, 3'b000});

  always_comb begin
    state_d  = state_q;
    ld_ch_d  = ld_ch_q;
    shift_en = 1'b0;
    commit   = 1'b0;
    if (cmd_ready) begin
      unique case (1'b1)
        is_ldp: begin
          state_d = LOADP;
          ld_ch_d = cch;
        end
        is_ldm: begin
          state_d = LOADM;
          ld_ch_d = cch;
        end
        default: state_d = IDLE;
      endcase
    end else if (param_ready && state_q != IDLE
                 && ld_byte) begin
      shift_en = 1'b1;
      if (ld_last) begin
        commit  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  assign cmt_p = commit && state_q == LOADP;
  assign cmt_m = commit && state_q == LOADM;

  // A held internal step re-tries after a same-channel DMA step.
  assign dma_ok  = dma_nextaddr && int'(dma_tgt) < NCH;
  assign isrc_v  = pend_q || int_req_q;
  assign isrc_ch = pend_q ? pend_ch_q : int_ch_q;
  assign collide = dma_ok && isrc_v && dma_tgt == isrc_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_ch_q   <= '0;
      rb_q      <= 1'b0;
      rb_ch_q   <= '0;
      rq_q      <= 1'b0;
      hist_q    <= '0;
      int_req_q <= 1'b0;
      int_ch_q  <= '0;
      pend_q    <= 1'b0;
      pend_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_ch_q   <= ld_ch_d;
      rq_q      <= mcu_rq_rdy;
      hist_q    <= {hist_q[1:0], rq_q};
      int_req_q <= hist_q == 3'b001 && int_cmd;
      int_ch_q  <= cch;
      pend_q    <= collide
                && !(cmt_p && ld_ch_q == isrc_ch);
      pend_ch_q <= isrc_ch;
      if (cmd_ready) begin
        rb_q    <= is_rb;
        rb_ch_q <= cch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_data_out <= 8'h00;
    end else if (cmd_ready) begin
      unique case (1'b1)
        is_rb:   spi_data_out <= rb_msb;
        is_id:   spi_data_out <= 8'hA5;
        default: spi_data_out <= spi_data_out;
      endcase
    end else if (param_ready && rb_q) begin
      spi_data_out <= rb_in ? rb_sel : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        p_q[c] <= '0;
        s_q[c] <= '0;
        m_q[c] <= '1;
        d_q[c] <= 8'd1;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cmt_p && ld_ch_q == 3'(c))
          p_q[c] <= s_new;
        else if ((dma_ok && dma_tgt == 3'(c))
                 || (isrc_v && !collide
                     && isrc_ch == 3'(c)))
          p_q[c] <= step(p_q[c], d_q[c], m_q[c]);
        if (cmt_m && ld_ch_q == 3'(c))
          m_q[c] <= s_new;
        if (cmd_ready && (is_ldp || is_ldm)
            && cch == 3'(c))
          s_q[c] <= '0;
        else if (shift_en && ld_ch_q == 3'(c))
          s_q[c] <= s_new;
        if (param_ready && is_ldd && cch == 3'(c)
            && spi_byte_cnt == 32'd2)
          d_q[c] <= (param_data == 8'd0) ? 8'd1
                                         : param_data;
      end
    end
  end

  assign load_busy = state_q != IDLE;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign addr_out[g*AW +: AW] = p_q[g];
  end

endmodule
